// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift pipeline.
//   shift_op_t : operation encoding carried on in_op (SLL/SRL/SRA, 3 is illegal)
//   SHAMT_W    : number of shift-amount bits that select a position in a 32-bit
//                word; any higher set bit means "shift everything out"
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SLL     = 2'd0,
    SRL     = 2'd1,
    SRA     = 2'd2,
    ILLEGAL = 2'd3
  } shift_op_t;

endpackage

// File: rtl/shift_datapath.sv
// -----------------------------------------------------------------------------
// shift_datapath
// Purely combinational shift unit used by the S2 stage of shift_pipe.
// Ports:
//   op     in  shift_op_t  operation (ILLEGAL yields result 0 and err 1)
//   a      in  N           operand
//   shamt  in  SHAMT_W     low bits of the shift amount
//   big    in  1           some shift-amount bit above SHAMT_W was set
//   result out N           shifted value
//   err    out 1           op was illegal
// -----------------------------------------------------------------------------
module shift_datapath
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  shift_op_t            op,
  input  logic [N-1:0]         a,
  input  logic [SHAMT_W-1:0]   shamt,
  input  logic                 big,
  output logic [N-1:0]         result,
  output logic                 err
);

  logic [N-1:0] sll_val;
  logic [N-1:0] srl_val;
  logic [N-1:0] sra_val;

  // Shift amounts of N or more push every bit out: logical shifts collapse to
  // zero, the arithmetic shift collapses to a full sign fill.
  assign sll_val = big ? '0 : (a << shamt);
  assign srl_val = big ? '0 : (a >> shamt);
  assign sra_val = big ? {N{a[N-1]}} : $unsigned($signed(a) >>> shamt);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      SLL:     result = sll_val;
      SRL:     result = srl_val;
      SRA:     result = sra_val;
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Two-stage valid/ready shift pipeline. S1 captures the operation, S2 holds the
// computed result. One op per cycle when downstream is ready; up to two ops are
// buffered when it stalls.
// Ports:
//   clk        in  1          clock, rising edge
//   rst_n      in  1          asynchronous active-low reset
//   flush      in  1          synchronous drop of all in-flight ops
//   in_valid   in  1          upstream op present
//   in_ready   out 1          op is accepted this cycle
//   in_op      in  shift_op_t operation
//   in_a       in  N          operand
//   in_shamt   in  N          full-width unsigned shift amount
//   out_valid  out 1          result present
//   out_ready  in  1          downstream takes the result
//   out_result out N          shifted result (0 when out_valid is 0)
//   out_err    out 1          result came from an illegal op (0 when idle)
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  shift_op_t    in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_err
);

  // S1: captured operation
  logic               s1_valid_reg;
  shift_op_t          s1_op_reg;
  logic [N-1:0]       s1_a_reg;
  logic [SHAMT_W-1:0] s1_shamt_reg;
  logic               s1_big_reg;

  // S2: computed result
  logic               s2_valid_reg;
  logic [N-1:0]       s2_result_reg;
  logic               s2_err_reg;

  logic               s1_adv;
  logic               accept;
  logic [N-1:0]       dp_result;
  logic               dp_err;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign s1_adv   = !s2_valid_reg || out_ready;

  // rst_n gates ready combinationally so the port reads 0 the instant reset
  // asserts, not just after the next edge.
  assign in_ready = rst_n && !flush && (!s1_valid_reg || s1_adv);
  assign accept   = in_valid && in_ready;

  shift_datapath #(
    .N (N)
  ) u_datapath (
    .op     (s1_op_reg),
    .a      (s1_a_reg),
    .shamt  (s1_shamt_reg),
    .big    (s1_big_reg),
    .result (dp_result),
    .err    (dp_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= SLL;
      s1_a_reg     <= '0;
      s1_shamt_reg <= '0;
      s1_big_reg   <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_op_reg    <= in_op;
      s1_a_reg     <= in_a;
      s1_shamt_reg <= in_shamt[SHAMT_W-1:0];
      s1_big_reg   <= |in_shamt[N-1:SHAMT_W];
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_err_reg    <= 1'b0;
    end else if (flush) begin
      s2_valid_reg  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_reg  <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= dp_result;
        s2_err_reg    <= dp_err;
      end
    end
  end

  // Outputs read as zero whenever no result is being presented.
  assign out_valid  = s2_valid_reg;
  assign out_result = s2_valid_reg ? s2_result_reg : '0;
  assign out_err    = s2_valid_reg && s2_err_reg;

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Directed self-checking bench for shift_pipe.
// -----------------------------------------------------------------------------
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  shift_op_t   in_op = SLL;
  logic [31:0] in_a = '0;
  logic [31:0] in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_err;

  int n_vec  = 0;
  int n_miss = 0;

  shift_pipe #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Presents one op to an idle pipe with out_ready high and reports the first
  // result seen plus how many cycles after presentation it appeared.
  task automatic send_one(input shift_op_t op, input logic [31:0] a,
                          input logic [31:0] sh, output logic [31:0] res,
                          output logic err, output int lat, output logic got);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_shamt = sh; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0; res = '0; err = 1'b0; lat = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; lat = c; res = out_result; err = out_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #12;
    n_vec++;
    if (in_ready !== 1'b0) begin n_miss++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_result !== 32'h0 || out_err !== 1'b0) begin
      n_miss++; $display("FAIL reset_out_data: got %h/%b want 00000000/0", out_result, out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_sra();
    logic [31:0] res; logic err; int lat; logic got;
    send_one(SRA, 32'h8000_0000, 32'd4, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || lat != 2) begin n_miss++; $display("FAIL sra_latency: got valid=%b lat=%0d want valid=1 lat=2", got, lat); end
    n_vec++;
    if (res !== 32'hF800_0000) begin n_miss++; $display("FAIL sra_result: got %h want f8000000", res); end
    n_vec++;
    if (err !== 1'b0) begin n_miss++; $display("FAIL sra_err: got %b want 0", err); end
    $display("test_sra: result %h err %b lat %0d", res, err, lat);
  endtask

  task automatic test_big_shamt();
    logic [31:0] res; logic err; int lat; logic got;
    send_one(SRA, 32'h8000_0001, 32'h0000_0020, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL big_sra_neg: got %h want ffffffff", res); end
    $display("big SRA neg: result %h", res);
    send_one(SRL, 32'h8000_0001, 32'h0000_0020, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'h0) begin n_miss++; $display("FAIL big_srl: got %h want 00000000", res); end
    $display("big SRL: result %h", res);
    send_one(SLL, 32'h0000_0001, 32'h0000_0100, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'h0) begin n_miss++; $display("FAIL big_sll: got %h want 00000000", res); end
    $display("big SLL: result %h", res);
    send_one(SRA, 32'h4000_0000, 32'hFFFF_FFFF, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'h0) begin n_miss++; $display("FAIL big_sra_pos: got %h want 00000000", res); end
    $display("big SRA pos: result %h", res);
    send_one(SRA, 32'h8000_0000, 32'd31, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL sra_31: got %h want ffffffff", res); end
    $display("SRA by 31: result %h", res);
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic err; int lat; logic got;
    send_one(ILLEGAL, 32'h0000_1234, 32'd1, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || res !== 32'h0) begin n_miss++; $display("FAIL illegal_result: got %h want 00000000", res); end
    n_vec++;
    if (err !== 1'b1) begin n_miss++; $display("FAIL illegal_err: got %b want 1", err); end
    $display("test_illegal: result %h err %b", res, err);
  endtask

  task automatic test_back_to_back();
    shift_op_t   vo[8] = '{SLL, SRL, SRA, SLL, SRL, SRA, SLL, SRA};
    logic [31:0] va[8] = '{32'h0000_0001, 32'h8000_0000, 32'hF000_0000, 32'h0000_FFFF,
                           32'h1234_5678, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000};
    logic [31:0] vs[8] = '{32'd4, 32'd31, 32'd4, 32'd16, 32'd8, 32'd30, 32'd0, 32'h40};
    logic [31:0] ve[8] = '{32'h0000_0010, 32'h0000_0001, 32'hFF00_0000, 32'hFFFF_0000,
                           32'h0012_3456, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    int i = 0;
    int k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (i < 8);
      if (i < 8) begin in_op = vo[i]; in_a = va[i]; in_shamt = vs[i]; end
      @(negedge clk);
      if (cyc == 3) begin
        n_vec++;
        if (in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_ready_drop: got %b want 0", in_ready); end
      end
      if (out_valid && !out_ready) begin
        n_vec++;
        if (out_result !== ve[k]) begin n_miss++; $display("FAIL b2b_hold[%0d]: got %h want %h", k, out_result, ve[k]); end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_result !== ve[k] || out_err !== 1'b0) begin
          n_miss++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/0", k, out_result, out_err, ve[k]);
        end
        $display("b2b out[%0d]: result %h", k, out_result);
        k++;
      end
      if (in_valid && in_ready) i++;
      n_vec++;
      if (i - k > 2) begin n_miss++; $display("FAIL b2b_in_flight: got %0d want <=2", i - k); end
    end
    in_valid = 1'b0;
    n_vec++;
    if (i != 8 || k != 8) begin n_miss++; $display("FAIL b2b_count: got in=%0d out=%0d want 8/8", i, k); end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = SLL; in_a = 32'h1; in_shamt = 32'd1;
    @(posedge clk); #1;
    in_op = SRL; in_a = 32'h100; in_shamt = 32'd4;
    @(posedge clk); #1;
    in_op = SRA; in_a = 32'h8000_0000; in_shamt = 32'd1; flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1) begin n_miss++; $display("FAIL flush_setup: got out_valid %b want 1", out_valid); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_miss++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      n_miss++; $display("FAIL flush_clear: got %b/%h want 0/00000000", out_valid, out_result);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_miss++; $display("FAIL flush_leak: got out_valid 1 want 0"); end
    $display("test_flush: pipeline empty after flush");
  endtask

  task automatic test_async_reset();
    logic [31:0] res; logic err; int lat; logic got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = SRL; in_a = 32'hF0; in_shamt = 32'd4; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1) begin n_miss++; $display("FAIL arst_setup: got out_valid %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b0) begin
      n_miss++; $display("FAIL arst_immediate: got valid=%b result=%h ready=%b want 0/00000000/0", out_valid, out_result, in_ready);
    end
    @(negedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    send_one(SLL, 32'h3, 32'd2, res, err, lat, got);
    n_vec++;
    if (got !== 1'b1 || lat != 2 || res !== 32'hC || err !== 1'b0) begin
      n_miss++; $display("FAIL arst_first_op: got valid=%b lat=%0d result=%h err=%b want 1/2/0000000c/0", got, lat, res, err);
    end
    $display("test_async_reset: first op result %h lat %0d", res, lat);
  endtask

  initial begin
    test_reset();
    test_sra();
    test_big_shamt();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter N, default 32, datapath width; only N=32 need be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous clear of all in-flight operations.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 in_op  input  2  shift_op_t: SLL=0, SRL=1, SRA=2, 3=illegal.
REQ-008 in_a  input  N  operand to shift.
REQ-009 in_shamt  input  N  full-width shift amount, unsigned.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_result  output  N  shifted result.
REQ-013 out_err  output  1  result came from illegal op (qualified by out_valid).

Function
REQ-014 Transfer on either port SHALL occur only when valid and ready are both high on the same rising edge.
REQ-015 Two register stages SHALL exist: S1 (operand capture), S2 (result); an accepted op SHALL reach out_valid exactly 2 cycles after acceptance when out_ready stays high.
REQ-016 in_ready SHALL equal !S1.valid | (S1 advances this cycle); S1 advances when !S2.valid | out_ready.
REQ-017 Sustained throughput SHALL be one op per cycle with out_ready held high.
REQ-018 With out_ready low, S2 and out_result SHALL hold stable; S1 SHALL hold; at most 2 ops in flight; no op lost or duplicated.
REQ-019 S1 SHALL register op, a, shamt[4:0], and big = |shamt[N-1:5].
REQ-020 S2 result: big=0 -> SLL a<<shamt, SRL logical a>>shamt, SRA arithmetic a>>>shamt.
REQ-021 big=1 -> SLL and SRL give 0; SRA gives N copies of a[N-1] (0 or all ones).
REQ-022 Illegal op SHALL produce out_result=0, out_err=1; legal ops out_err=0.
REQ-023 flush SHALL clear S1.valid and S2.valid on the next edge, overriding any simultaneous acceptance; in_ready SHALL be 0 during the flush cycle.
REQ-024 When out_valid is 0, out_result and out_err SHALL be 0.

Reset
REQ-025 rst_n low SHALL immediately force S1.valid=0, S2.valid=0, out_valid=0, out_result=0, out_err=0, in_ready=0.
REQ-026 in_ready SHALL rise the first cycle after rst_n deasserts; ops in flight at reset are discarded.

Structure
REQ-027 Package shift_pkg SHALL hold shift_op_t enum and localparam SHAMT_W=5.
REQ-028 One sub-module shift_datapath (combinational: op, a, shamt, big -> result, err) SHALL implement REQ-020..022, reusing the team's existing left, logical-right, arithmetic-right shifters.
REQ-029 Pipeline control (valid/ready, flush) SHALL live in shift_pipe only.

Verification
REQ-030 SRA a=0x80000000 shamt=4, out_ready=1 -> out_result=0xF8000000, out_err=0, 2 cycles after accept.
REQ-031 SRA a=0x80000001 shamt=0x00000020 -> 0xFFFFFFFF; SRL same inputs -> 0; SLL a=1 shamt=0x100 -> 0.
REQ-032 Back-to-back 8 random ops, out_ready low 3 cycles mid-stream -> in_ready drops after 2 buffered, results in order, none lost.
REQ-033 in_op=3, a=0x1234 -> out_result=0, out_err=1.
REQ-034 flush asserted with 2 ops in flight and in_valid=1 -> next cycle out_valid=0, nothing emerges later.
REQ-035 rst_n pulsed low mid-stream (asynchronous to clk) -> out_valid=0 immediately; first post-reset op completes with correct value.
